aud_i2s_tx: RTL and testbench

I2S serializer directly downstream of the playback DSP stage. It captures the 16-bit signed DAC sample once per DACLRCK frame and shifts it MSB-first onto the WM8731 DACDAT pin in standard I2S format. The codec is the clock master and drives both BCLK and DACLRCK. The block also reports frame boundaries and sync slips to the top level.

---
 rtl/aud_i2s_tx.sv | 168 ++++++++++++++++
 tb/tb_aud_i2s_tx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/aud_i2s_tx.sv
// aud_i2s_tx
//   I2S transmitter for the WM8731 DAC path. The codec is the clock master
//   and drives BCLK and DACLRCK. One sample is captured on each DACLRCK
//   falling edge and shifted out MSB-first, after the one-bit I2S delay.
//   All flops update on the falling edge of BCLK, so the codec samples each
//   bit on the following rising edge.
//
//   Build option: define AUD_I2S_TX_STEREO_EN to add i_dac_data_r. The right
//   slot then carries its own sample. Without it, the right slot repeats the
//   left sample.
//
// Ports
//   i_clk          codec BCLK (negedge active)
//   i_rst_n        async active-low reset
//   i_en           transmit enable; low forces IDLE, silence, clears slip
//   i_daclrck      codec DACLRCK (0 = left slot, 1 = right slot)
//   i_dac_data     signed sample for the left slot (and the right slot in mono)
//   i_dac_data_r   right-slot sample (stereo builds only)
//   i_valid        sample qualifier, sampled only at capture
//   o_aud_dacdat   serial data to the codec
//   o_frame        one-BCLK pulse on each left-slot capture
//   o_busy         state is not IDLE or SYNC
//   o_slip         sticky: an LRCK edge arrived while a word was still going out
module aud_i2s_tx #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_daclrck,
  input  logic [WIDTH-1:0] i_dac_data,
`ifdef AUD_I2S_TX_STEREO_EN
  input  logic [WIDTH-1:0] i_dac_data_r,
`endif
  input  logic             i_valid,
  output logic             o_aud_dacdat,
  output logic             o_frame,
  output logic             o_busy,
  output logic             o_slip
);

  typedef enum logic [2:0] {IDLE, SYNC, LSEND, LPAD, RSEND, RPAD} state_t;

  state_t           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] rh_q, rh_d;
  logic             dat_q, dat_d;
  logic             frame_q, frame_d;
  logic             slip_q, slip_d;
  logic             lrck_q;

  logic             fall, rise;
  logic             do_cap, do_rload;
  logic [WIDTH-1:0] cap_l, cap_r;

  assign fall = lrck_q & ~i_daclrck;
  assign rise = ~lrck_q & i_daclrck;

  // Invalid samples become silence for both slots of the frame.
  assign cap_l = i_valid ? i_dac_data : '0;
`ifdef AUD_I2S_TX_STEREO_EN
  assign cap_r = i_valid ? i_dac_data_r : '0;
`else
  assign cap_r = cap_l;
`endif

  always_ff @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      rh_q    <= '0;
      dat_q   <= 1'b0;
      frame_q <= 1'b0;
      slip_q  <= 1'b0;
      lrck_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      rh_q    <= rh_d;
      dat_q   <= dat_d;
      frame_q <= frame_d;
      slip_q  <= slip_d;
      lrck_q  <= i_daclrck;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    rh_d     = rh_q;
    dat_d    = dat_q;
    frame_d  = 1'b0;
    slip_d   = slip_q;
    do_cap   = 1'b0;
    do_rload = 1'b0;

    if (!i_en) begin
      state_d = IDLE;
      dat_d   = 1'b0;
      slip_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          dat_d   = 1'b0;
          state_d = SYNC;
        end
        // Only a falling LRCK edge starts a frame, so enabling while
        // LRCK is high never begins in the right slot.
        SYNC: begin
          dat_d = 1'b0;
          if (fall) do_cap = 1'b1;
        end
        LSEND, RSEND: begin
          if (fall || rise) begin
            // The word is abandoned. The edge is handled as if the
            // word had already finished.
            slip_d = 1'b1;
            if (fall) do_cap   = 1'b1;
            else      do_rload = 1'b1;
          end else begin
            dat_d = sh_q[WIDTH-1];
            sh_d  = sh_q << 1;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(WIDTH-1))
              state_d = (state_q == LSEND) ? LPAD : RPAD;
          end
        end
        LPAD: begin
          dat_d = 1'b0;
          if (rise) do_rload = 1'b1;
        end
        RPAD: begin
          dat_d = 1'b0;
          if (fall) do_cap = 1'b1;
        end
        default: state_d = IDLE;
      endcase

      // Each branch drives 0 first. This is the I2S one-bit delay slot
      // before the MSB.
      if (do_cap) begin
        sh_d    = cap_l;
        rh_d    = cap_r;
        cnt_d   = '0;
        state_d = LSEND;
        frame_d = 1'b1;
        dat_d   = 1'b0;
      end
      if (do_rload) begin
        sh_d    = rh_q;
        cnt_d   = '0;
        state_d = RSEND;
        dat_d   = 1'b0;
      end
    end
  end

  assign o_aud_dacdat = dat_q;
  assign o_frame      = frame_q;
  assign o_slip       = slip_q;
  assign o_busy       = (state_q != IDLE) && (state_q != SYNC);

endmodule

// File: tb/tb_aud_i2s_tx.sv
// tb_aud_i2s_tx
//   Directed and randomized bench for aud_i2s_tx. The reference model does
//   not track any state machine. It uses the bit position inside each LRCK
//   half-period, counted in BCLK falling edges after the LRCK transition:
//     position 1             delay slot (0)
//     position 2..W+1        word bits, MSB first
//     later positions        padding (0)
//   A half-period of W or fewer edges cuts the word short, so the next
//   LRCK edge raises the sticky slip flag.
module tb_aud_i2s_tx;
  localparam int W = 16;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_en;
  logic         i_daclrck;
  logic [W-1:0] i_dac_data;
  logic [W-1:0] i_dac_data_r;
  logic         i_valid;
  logic         o_aud_dacdat, o_frame, o_busy, o_slip;

  aud_i2s_tx #(.WIDTH(W)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_en        (i_en),
    .i_daclrck   (i_daclrck),
    .i_dac_data  (i_dac_data),
`ifdef AUD_I2S_TX_STEREO_EN
    .i_dac_data_r(i_dac_data_r),
`endif
    .i_valid     (i_valid),
    .o_aud_dacdat(o_aud_dacdat),
    .o_frame     (o_frame),
    .o_busy      (o_busy),
    .o_slip      (o_slip)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic         m_prev;
  bit           m_idle, m_sync, m_slip, m_frame;
  int           m_p;
  logic [W-1:0] m_word, m_rw;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 1'b0; m_idle = 1'b1; m_sync = 1'b0; m_slip = 1'b0;
    m_frame = 1'b0; m_p = 0; m_word = '0; m_rw = '0;
  endtask

  task automatic model_capture();
    m_p     = 1;
    m_word  = i_valid ? i_dac_data : '0;
`ifdef AUD_I2S_TX_STEREO_EN
    m_rw    = i_valid ? i_dac_data_r : '0;
`else
    m_rw    = m_word;
`endif
    m_frame = 1'b1;
  endtask

  // Called on each BCLK falling edge, using the inputs at that edge.
  task automatic model_step();
    logic lr;
    lr = i_daclrck;
    m_frame = 1'b0;
    if (!i_en) begin
      m_idle = 1'b1; m_sync = 1'b0; m_slip = 1'b0;
    end else if (m_idle) begin
      m_idle = 1'b0;
    end else if (!m_sync) begin
      if (m_prev && !lr) begin
        m_sync = 1'b1;
        model_capture();
      end
    end else if (lr != m_prev) begin
      if (m_p <= W) m_slip = 1'b1;
      if (!lr) model_capture();
      else begin
        m_p = 1; m_word = m_rw;
      end
    end else begin
      m_p++;
    end
    m_prev = lr;
  endtask

  function automatic logic exp_dat();
    if (m_sync && m_p >= 2 && m_p <= W + 1) return m_word[W + 1 - m_p];
    return 1'b0;
  endfunction

  task automatic tick();
    @(negedge i_clk);
    model_step();
    #1;
    chk("dacdat", o_aud_dacdat, exp_dat());
    chk("frame",  o_frame,      m_frame);
    chk("slip",   o_slip,       m_slip);
    chk("busy",   o_busy,       m_sync);
  endtask

  task automatic half(input logic lv, input int n);
    i_daclrck = lv;
    repeat (n) tick();
  endtask

  task automatic rand_sample();
    i_dac_data   = W'($urandom);
    i_dac_data_r = W'($urandom);
    i_valid      = ($urandom % 4) != 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n = 1'b0; i_en = 1'b0; i_daclrck = 1'b0;
    i_dac_data = '0; i_dac_data_r = '0; i_valid = 1'b0;
    model_reset();
    #2;
    chk("rst_dacdat", o_aud_dacdat, 1'b0);
    chk("rst_frame",  o_frame,      1'b0);
    chk("rst_slip",   o_slip,       1'b0);
    chk("rst_busy",   o_busy,       1'b0);
    #5 i_rst_n = 1'b1;
    repeat (3) tick();

    // enable with LRCK high: must hold in SYNC
    i_en = 1'b1;
    half(1'b1, 6);

    // directed 64-BCLK frames
    i_dac_data = 16'hA5C3; i_dac_data_r = 16'h7FFE; i_valid = 1'b1;
`ifdef AUD_I2S_TX_STEREO_EN
    i_dac_data = 16'h8001;
`endif
    repeat (2) begin half(1'b0, 32); half(1'b1, 32); end

    // invalid sample -> silence
    i_dac_data = 16'hFFFF; i_dac_data_r = 16'hFFFF; i_valid = 1'b0;
    half(1'b0, 32); half(1'b1, 32);

    // random legal frames
    repeat (6) begin
      rand_sample();
      half(1'b0, W + 1 + int'($urandom % 8));
      half(1'b1, W + 1 + int'($urandom % 8));
    end

    // short left half: 10 bits then LRCK rises
    rand_sample(); i_valid = 1'b1;
    half(1'b0, 11); half(1'b1, 32);
    i_en = 1'b0; repeat (2) tick();

    // exact-boundary halves: W+1 is legal, W slips
    i_en = 1'b1;
    half(1'b1, 3);
    rand_sample(); half(1'b0, W + 1);
    half(1'b1, W + 1);
    rand_sample(); half(1'b0, W + 1);
    half(1'b1, W);
    rand_sample(); half(1'b0, 20);

    // drop enable after 7 data bits, re-enable with LRCK high
    half(1'b1, 20);
    rand_sample(); half(1'b0, 8);
    i_en = 1'b0; repeat (2) tick();
    i_daclrck = 1'b1; i_en = 1'b1;
    repeat (5) tick();
    rand_sample(); half(1'b0, 32); half(1'b1, 32);

    // async reset mid-word
    rand_sample(); half(1'b0, 10);
    #2 i_rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_dacdat", o_aud_dacdat, 1'b0);
    chk("mid_rst_frame",  o_frame,      1'b0);
    chk("mid_rst_slip",   o_slip,       1'b0);
    chk("mid_rst_busy",   o_busy,       1'b0);
    #2 i_rst_n = 1'b1;
    half(1'b0, 4); half(1'b1, 5);
    rand_sample(); half(1'b0, 32); half(1'b1, 32);

    // random half lengths around the legal minimum
    repeat (12) begin
      rand_sample();
      half(1'b0, W - 2 + int'($urandom % 8));
      half(1'b1, W - 2 + int'($urandom % 8));
      if (($urandom % 4) == 0) begin
        i_en = 1'b0; tick(); i_en = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
